frame_sync_fifo: RTL and testbench

Single-clock byte FIFO for Ethernet frame buffering, sitting between a MAC-side byte producer and a frame consumer. Each stored byte carries an end-of-data (EOD) marker bit, so frame boundaries pass through the queue intact. Exposes empty, almost-empty, full and almost-full status flags.

---
 rtl/frame_sync_fifo.sv | 135 +++++++++++++
 tb/tb_frame_sync_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_fifo.sv
// Single-clock byte FIFO for Ethernet frame buffering.
// Each entry is {EOD, data}, so frame boundaries travel through the queue
// with the bytes. Status flags are registered from the next-state occupancy,
// so they change on the same edge as the pointers and have no combinational
// path from we/re.
//
// Handshake: we and re are requests sampled on the rising edge. A write is
// accepted only when full_flag is low, and a read only when empty_flag is
// low; rejected requests have no effect at all. Read data appears on dout /
// EOD_out in the cycle after the accepted read and holds until the next one.
//
// The read-data port is named dout because "do" is a reserved word.
module frame_sync_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 11,
    parameter int AEMPTY_LEVEL = 4,
    parameter int AFULL_LEVEL  = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [DATA_WIDTH-1:0] di,
    input  logic                  we,
    input  logic                  EOD_in,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  EOD_out,
    output logic                  empty_flag,
    output logic                  aempty_flag,
    output logic                  full_flag,
    output logic                  afull_flag
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Occupancy thresholds expressed in counter width.
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_CNT = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AFULL_CNT  = (ADDR_WIDTH + 1)'(DEPTH - AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    // Storage; contents are intentionally not reset.
    logic [DATA_WIDTH:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  eod_q, eod_d;
    logic                  empty_q, empty_d;
    logic                  aempty_q, aempty_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;

    logic wr_en;
    logic rd_en;
    logic [DATA_WIDTH:0] rd_word;

    // Accepted-transfer qualification from the registered flags only.
    always_comb begin
        wr_en   = we & ~full_q;
        rd_en   = re & ~empty_q;
        rd_word = mem[rd_ptr_q];
    end

    // Next-state pointers, occupancy, read data and flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        eod_d    = eod_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = rd_word[DATA_WIDTH-1:0];
            eod_d    = rd_word[DATA_WIDTH];
        end

        // Simultaneous accepted read and write leaves occupancy unchanged.
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        empty_d  = (count_d == '0);
        aempty_d = (count_d <= AEMPTY_CNT);
        full_d   = (count_d == DEPTH_CNT);
        afull_d  = (count_d >= AFULL_CNT);
    end

    // Memory write port; the pointer is only advanced on accepted writes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {EOD_in, di};
        end
    end

    // Control and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            eod_q    <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            eod_q    <= eod_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
        end
    end

    assign dout        = dout_q;
    assign EOD_out     = eod_q;
    assign empty_flag  = empty_q;
    assign aempty_flag = aempty_q;
    assign full_flag   = full_q;
    assign afull_flag  = afull_q;

endmodule

// File: tb/tb_frame_sync_fifo.sv
// Bench for frame_sync_fifo with a 16-deep configuration.
// A queue-based reference holds the stored words; a compare process checks
// every DUT output against it on each falling edge, and the directed
// sequences add literal checks that pin the reference itself.
module tb_frame_sync_fifo;

    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int AE_LVL = 4;
    localparam int AF_LVL = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    logic [DW-1:0] di;
    logic          we;
    logic          EOD_in;
    logic          re;
    logic [DW-1:0] dout;
    logic          EOD_out;
    logic          empty_flag;
    logic          aempty_flag;
    logic          full_flag;
    logic          afull_flag;

    frame_sync_fifo #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .AEMPTY_LEVEL(AE_LVL),
        .AFULL_LEVEL (AF_LVL)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .di         (di),
        .we         (we),
        .EOD_in     (EOD_in),
        .re         (re),
        .dout       (dout),
        .EOD_out    (EOD_out),
        .empty_flag (empty_flag),
        .aempty_flag(aempty_flag),
        .full_flag  (full_flag),
        .afull_flag (afull_flag)
    );

    // ---------------- counters / check helper ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] m_dout;
    logic          m_eod;
    logic          m_rd;
    logic          m_wr;
    logic [DW:0]   m_word;

    // Queue semantics: a read pops the oldest word, a write appends.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            exp_q.delete();
            m_dout = '0;
            m_eod  = 1'b0;
        end else begin
            m_rd = re && (exp_q.size() != 0);
            m_wr = we && (exp_q.size() != DEPTH);
            if (m_rd) begin
                m_word = exp_q.pop_front();
                m_dout = m_word[DW-1:0];
                m_eod  = m_word[DW];
            end
            if (m_wr) exp_q.push_back({EOD_in, di});
        end
    end

    // Compare DUT outputs with the reference every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_dout",   dout,        m_dout);
            chk("cmp_eod",    EOD_out,     m_eod);
            chk("cmp_empty",  empty_flag,  exp_q.size() == 0);
            chk("cmp_aempty", aempty_flag, exp_q.size() <= AE_LVL);
            chk("cmp_full",   full_flag,   exp_q.size() == DEPTH);
            chk("cmp_afull",  afull_flag,  exp_q.size() >= DEPTH - AF_LVL);
        end
    end

    // ---------------- driver ----------------
    // Called at a falling edge; drives inputs and returns at the next one.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic e);
        we     = w;
        re     = r;
        di     = d;
        EOD_in = e;
        @(negedge clk);
    endtask

    // Overall time bound.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    logic [DW-1:0] wrap_v;

    initial begin
        arst_n = 1'b0;
        we = 1'b0; re = 1'b0; di = '0; EOD_in = 1'b0;

        // Reset held with toggling requests.
        @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        chk("rst_dout",   dout,        0);
        chk("rst_eod",    EOD_out,     0);
        chk("rst_empty",  empty_flag,  1);
        chk("rst_aempty", aempty_flag, 1);
        chk("rst_full",   full_flag,   0);
        chk("rst_afull",  afull_flag,  0);
        arst_n = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);

        // Fill: 20 writes, the last 4 must be dropped.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            chk("fill_afull",  afull_flag,  (i + 1) >= 12);
            chk("fill_full",   full_flag,   (i + 1) >= 16);
            chk("fill_aempty", aempty_flag, (i + 1) <= 4);
        end

        // Drain: data 0x00..0x0F in order, then hold.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, '0, 1'b0);
            chk("drain_dout",  dout,       (i < 16) ? i : 32'h0F);
            chk("drain_empty", empty_flag, (i + 1) >= 16);
        end

        // Concurrent stream at constant occupancy 8.
        for (int c = 0; c < 32; c++) begin
            step(1'b1, c >= 8, 8'(8'h40 + c), 1'b0);
            if (c >= 8) begin
                chk("strm_dout",   dout,        8'h40 + (c - 8));
                chk("strm_aempty", aempty_flag, 0);
                chk("strm_afull",  afull_flag,  0);
            end
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, '0, 1'b0);
            chk("strm_tail", dout, (k < 8) ? (8'h58 + k) : 8'h5F);
        end
        chk("strm_empty", empty_flag, 1);

        // EOD passthrough.
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        step(1'b1, 1'b0, 8'hBB, 1'b0);
        step(1'b1, 1'b0, 8'hCC, 1'b1);
        step(1'b0, 1'b1, '0, 1'b0);
        chk("eod_d0", {EOD_out, dout}, 9'h0AA);
        step(1'b0, 1'b1, '0, 1'b0);
        chk("eod_d1", {EOD_out, dout}, 9'h0BB);
        step(1'b0, 1'b1, '0, 1'b0);
        chk("eod_d2", {EOD_out, dout}, 9'h1CC);

        // Write/read pairs across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            wrap_v = 8'($urandom_range(0, 255));
            step(1'b1, 1'b0, wrap_v, i[0]);
            step(1'b0, 1'b1, '0, 1'b0);
            chk("wrap_data", {EOD_out, dout}, {i[0], wrap_v});
        end

        // Mid-operation reset with 5 entries stored.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
        chk("pre_rst_aempty", aempty_flag, 0);
        we = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        chk("mid_rst_empty",  empty_flag,  1);
        chk("mid_rst_aempty", aempty_flag, 1);
        chk("mid_rst_dout",   dout,        0);
        @(negedge clk);
        step(1'b1, 1'b1, 8'h99, 1'b1);
        arst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, '0, 1'b0);
            chk("post_rst_dout",  dout,       0);
            chk("post_rst_empty", empty_flag, 1);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
